dm_timer_responder: RTL and testbench
=====================================

# dm_timer_responder

Memory-mapped timer peripheral that responds on the core's data-memory bus, using the same request/we_re/mask/valid/load handshake the core drives toward the data memory. It holds a free-running 64-bit time counter, a 64-bit compare register and a control register, and raises a registered interrupt when time reaches compare. It sits beside the data memory, and an address decode in the top level selects between the two.

## Interface
- WAIT_STATES, default 1: cycles inserted between request acceptance and the valid response (0..15).
- ADDR_W, default 8: word-address width.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- request  input  1  bus transaction request, sampled only in IDLE.
- we_re  input  1  1 = write, 0 = read.
- load  input  1  read qualifier from the core; accepted but not used by this block (reads return the full word).
- address  input  ADDR_W  word address.
- data_in  input  32  write data.
- mask  input  4  byte enables, bit i selects data_in[8i+7:8i].
- valid  output  1  one-cycle response strobe.
- data_out  output  32  read data, meaningful only while valid=1.
- timer_irq  output  1  timer interrupt, level.

## Operation
- Register map (word address):
  - 0 CTRL: bit0 enable. Other bits read 0.
  - 1 PRESCALE: bits[15:0].
  - 2 TIME_LO, 3 TIME_HI.
  - 4 CMP_LO, 5 CMP_HI.
  - 6 STATUS: bit0 is a read-only copy of timer_irq.
  - All other addresses: reads return 0, writes are ignored, valid is still returned.
- Writes are byte-masked: only the enabled bytes update; mask=0000 is a legal no-op that still returns valid.
- Counting: when enable=1, a prescale counter counts 0..PRESCALE. On wrap it resets to 0 and TIME increments by 1 as a 64-bit value, with carry from LO into HI. PRESCALE=0 means increment every cycle.
- timer_irq is registered: it updates every cycle to enable && (TIME >= CMP), using a 64-bit unsigned compare. It stays asserted until CMP is raised, TIME is rewritten, or enable is cleared.
- FSM states:
  - IDLE: request=1 captures address, we_re, data_in and mask. Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - WAIT: a down-counter loaded with WAIT_STATES-1 counts to 0, then the FSM goes to RESP.
  - RESP: valid=1. A write takes effect at this clock edge; data_out carries the read value sampled this cycle. Return to IDLE.
- Requests arriving outside IDLE are ignored, not queued. The master must hold request until it sees valid; a request still high in the cycle after RESP starts a new transaction.

## Timing
- Reset values: valid=0, data_out=0, timer_irq=0, CTRL=0, PRESCALE=0, TIME=0, CMP=all ones, FSM=IDLE, prescale and wait counters 0.
- Latency: with request accepted at edge N, valid=1 in the cycle after edge N+WAIT_STATES (e.g. WAIT_STATES=1 gives valid 2 cycles after request is sampled). Minimum transaction period is WAIT_STATES+2 cycles.
- A write to TIME_LO/HI in the same cycle as an increment: the written bytes win, unwritten bytes take the incremented value.
- A write to CTRL.enable or PRESCALE restarts the prescale counter at 0.
- TIME wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 silently.
- timer_irq lags a TIME or CMP change by exactly one cycle.
- Reset asserted mid-transaction: the transaction is aborted and no valid is produced. All state returns to reset values asynchronously.

## Configuration
- TIMER_PRESCALE_EN defined: PRESCALE register and prescale counter are present, as described above.
- Not defined: no prescale logic. TIME increments every enabled cycle, PRESCALE reads 0 and writes to it are ignored.

## Test plan
- Reset, then read CMP_LO with WAIT_STATES=1 -> valid 2 cycles after request, data_out=0xFFFF_FFFF. timer_irq=0 throughout.
- Write CTRL=1, PRESCALE=3, wait 40 cycles, read TIME_LO -> 10 ±1 increments, one increment per 4 cycles.
- Write TIME_LO=0xFFFF_FFFF with enable=1 and PRESCALE=0 -> TIME_HI reads 1 after the carry.
- Write CMP=0x0000_0000_0000_0010, enable -> timer_irq rises the cycle after TIME reaches 0x10. Writing CMP_LO=0x100 drops it one cycle later.
- Write TIME_LO data 0xAABBCCDD with mask=0010 while disabled -> TIME_LO reads 0x0000CC00.
- Hold request high during WAIT, then assert rst mid-WAIT -> no valid pulse, all registers reset, next request after release is served normally.

Source files
------------

// File: rtl/dm_timer_responder_if.sv
// Data-memory style bus between the core (master) and the timer responder (slave).
interface dm_timer_responder_if #(
    parameter int ADDR_W = 8
);
    logic              request;
    logic              we_re;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [3:0]        mask;
    logic              valid;
    logic [31:0]       data_out;

    modport master (
        output request, we_re, load, address, data_in, mask,
        input  valid, data_out
    );

    modport slave (
        input  request, we_re, load, address, data_in, mask,
        output valid, data_out
    );
endinterface

// File: rtl/dm_timer_responder.sv
// Memory-mapped 64-bit timer with compare interrupt on the data-memory bus.
// Define TIMER_PRESCALE_EN to build the PRESCALE register and prescale counter.
//
// state  | meaning
// IDLE   | waiting for request; captures the transaction
// WAIT   | counting down the configured wait states
// RESP   | valid=1, read data driven, write applied at the closing edge
module dm_timer_responder #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    dm_timer_responder_if.slave bus,
    output logic                timer_irq
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PS     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TLO    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_THI    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CLO    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CHI    = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(6);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q;
    logic [3:0]        wait_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic              valid_q;

    logic              en_q, en_d;
    logic [63:0]       time_q, time_d;
    logic [63:0]       cmp_q, cmp_d;
    logic              irq_q;
    logic              tick;
    logic [63:0]       time_inc;
    logic [15:0]       ps_rd;
    logic [31:0]       rdata;
    logic              wr_now, wr_ctrl, wr_tlo, wr_thi, wr_clo, wr_chi;
    logic              unused_load;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.request) begin
                        addr_q  <= bus.address;
                        we_q    <= bus.we_re;
                        wdata_q <= bus.data_in;
                        mask_q  <= bus.mask;
                        if (WAIT_STATES > 0) begin
                            state_q <= S_WAIT;
                            wait_q  <= WS_LOAD;
                        end else begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register writes land on the edge that closes the RESP cycle.
    assign wr_now  = valid_q && we_q;
    assign wr_ctrl = wr_now && (addr_q == A_CTRL);
    assign wr_tlo  = wr_now && (addr_q == A_TLO);
    assign wr_thi  = wr_now && (addr_q == A_THI);
    assign wr_clo  = wr_now && (addr_q == A_CLO);
    assign wr_chi  = wr_now && (addr_q == A_CHI);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q;
    logic [15:0] pcnt_q;
    logic        wr_ps;
    logic        restart;

    assign wr_ps   = wr_now && (addr_q == A_PS);
    assign restart = (wr_ctrl && mask_q[0]) || (wr_ps && (|mask_q[1:0]));
    assign tick    = en_q && (pcnt_q == prescale_q);
    assign ps_rd   = prescale_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            if (wr_ps && mask_q[0]) prescale_q[7:0]  <= wdata_q[7:0];
            if (wr_ps && mask_q[1]) prescale_q[15:8] <= wdata_q[15:8];
            if (restart || !en_q || tick) pcnt_q <= '0;
            else                          pcnt_q <= pcnt_q + 16'd1;
        end
    end
`else
    assign tick  = en_q;
    assign ps_rd = '0;
`endif

    assign time_inc = time_q + 64'(tick);

    // Written bytes override the increment that happens on the same edge.
    always_comb begin
        time_d = time_inc;
        if (wr_tlo) time_d[31:0]  = merge_bytes(time_inc[31:0], wdata_q, mask_q);
        if (wr_thi) time_d[63:32] = merge_bytes(time_inc[63:32], wdata_q, mask_q);
        cmp_d = cmp_q;
        if (wr_clo) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], wdata_q, mask_q);
        if (wr_chi) cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata_q, mask_q);
        en_d = en_q;
        if (wr_ctrl && mask_q[0]) en_d = wdata_q[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            time_q <= '0;
            cmp_q  <= '1;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            time_q <= time_d;
            cmp_q  <= cmp_d;
            irq_q  <= en_q && (time_q >= cmp_q);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            A_CTRL:   rdata = {31'b0, en_q};
            A_PS:     rdata = {16'b0, ps_rd};
            A_TLO:    rdata = time_q[31:0];
            A_THI:    rdata = time_q[63:32];
            A_CLO:    rdata = cmp_q[31:0];
            A_CHI:    rdata = cmp_q[63:32];
            A_STATUS: rdata = {31'b0, irq_q};
            default:  rdata = '0;
        endcase
    end

    assign bus.valid    = valid_q;
    assign bus.data_out = valid_q ? rdata : '0;
    assign timer_irq    = irq_q;
    assign unused_load  = bus.load;
endmodule

// File: tb/tb_dm_timer_responder.sv
// Randomized bench for dm_timer_responder against a closed-form timer model.
`timescale 1ns/1ps
module tb_dm_timer_responder;
    localparam int WS = 1;
    localparam int AW = 8;
`ifdef TIMER_PRESCALE_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irq;

    dm_timer_responder_if #(.ADDR_W(AW)) bus();

    dm_timer_responder #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    logic [31:0] edge_cnt = '0;
    always @(posedge clk) edge_cnt <= edge_cnt + 32'd1;

    int checks = 0;
    int errors = 0;
    bit irq_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timer state as a closed form: after edge e (e >= bedge),
    // TIME = tbase + floor((ph0 + e - bedge) / (ps + 1)) while enabled.
    typedef struct packed {
        logic [63:0] tbase;
        logic [31:0] bedge;
        logic [31:0] ph0;
        logic        en;
        logic [31:0] ps;
        logic [63:0] cmp;
    } mdl_t;

    mdl_t cur, prv;

    function automatic mdl_t pick(input logic [31:0] e);
        return (e >= cur.bedge) ? cur : prv;
    endfunction

    function automatic logic [63:0] time_at(input logic [31:0] e);
        mdl_t m;
        logic [63:0] k;
        m = pick(e);
        k = 64'(e - m.bedge) + 64'(m.ph0);
        if (!m.en) return m.tbase;
        return m.tbase + k / 64'(m.ps + 32'd1);
    endfunction

    function automatic logic [31:0] phase_at(input logic [31:0] e);
        mdl_t m;
        m = pick(e);
        if (!m.en) return '0;
        return (e - m.bedge + m.ph0) % (m.ps + 32'd1);
    endfunction

    function automatic logic irq_at(input logic [31:0] e);
        mdl_t m;
        logic [31:0] p;
        p = e - 32'd1;
        m = pick(p);
        return m.en && (time_at(p) >= m.cmp);
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_model(input int addr, input logic [31:0] e);
        mdl_t m;
        logic [63:0] t;
        m = pick(e);
        t = time_at(e);
        case (addr)
            0: return {31'b0, m.en};
            1: return PS_EN ? m.ps : 32'd0;
            2: return t[31:0];
            3: return t[63:32];
            4: return m.cmp[31:0];
            5: return m.cmp[63:32];
            6: return {31'b0, irq_at(e)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void wr_model(input int addr, input logic [31:0] d,
                                     input logic [3:0] be, input logic [31:0] w);
        mdl_t n;
        logic [63:0] t;
        logic [31:0] p;
        t = time_at(w);
        n = cur;
        n.bedge = w;
        n.ph0 = phase_at(w);
        case (addr)
            0: if (be[0]) begin n.en = d[0]; n.ph0 = '0; end
            1: if (PS_EN && (|be[1:0])) begin
                   p = bmerge(cur.ps, d, {2'b00, be[1:0]});
                   n.ps = {16'b0, p[15:0]};
                   n.ph0 = '0;
               end
            2: t[31:0]  = bmerge(t[31:0], d, be);
            3: t[63:32] = bmerge(t[63:32], d, be);
            4: n.cmp[31:0]  = bmerge(cur.cmp[31:0], d, be);
            5: n.cmp[63:32] = bmerge(cur.cmp[63:32], d, be);
            default: ;
        endcase
        n.tbase = t;
        prv = cur;
        cur = n;
    endfunction

    function automatic void model_reset();
        cur.tbase = '0;
        cur.bedge = edge_cnt;
        cur.ph0   = '0;
        cur.en    = 1'b0;
        cur.ps    = '0;
        cur.cmp   = '1;
        prv = cur;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (irq_on) chk("irq", timer_irq, irq_at(edge_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic xact(input int addr, input bit we, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        rd = '0;
        bus.request = 1'b1;
        bus.we_re   = we;
        bus.load    = ~we;
        bus.address = AW'(addr);
        bus.data_in = d;
        bus.mask    = be;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (bus.valid) seen = 1'b1;
        end
        bus.request = 1'b0;
        if (!seen) begin
            chk("valid_timeout", 64'd0, 64'd1);
            return;
        end
        chk("latency", 64'(n), 64'(WS + 1));
        rd = bus.data_out;
        if (!we) chk($sformatf("read_a%0d", addr), rd, rd_model(addr, edge_cnt));
        else     wr_model(addr, d, be, edge_cnt + 32'd1);
        tick();
        chk("valid_pulse", bus.valid, 1'b0);
    endtask

    task automatic do_reset();
        irq_on = 1'b0;
        bus.request = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", bus.valid, 1'b0);
            chk("rst_irq", timer_irq, 1'b0);
            chk("rst_data", bus.data_out, 32'd0);
        end
        rst = 1'b1;
        model_reset();
        irq_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int a;
        bit w;
        logic [31:0] d;

        bus.request = 1'b0;
        bus.we_re   = 1'b0;
        bus.load    = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        bus.mask    = '0;
        #1 rst = 1'b0;
        do_reset();

        xact(4, 0, 0, 4'hF, rd);
        chk("cmp_lo_reset", rd, 32'hFFFF_FFFF);
        xact(6, 0, 0, 4'hF, rd);
        chk("status_reset", rd, 32'd0);

        xact(0, 1, 32'd1, 4'hF, rd);
        xact(1, 1, 32'd3, 4'hF, rd);
        idle(40);
        xact(2, 0, 0, 4'hF, rd);
        if (PS_EN) chk("time_prescaled", (rd >= 9 && rd <= 11), 1'b1);
        xact(1, 0, 0, 4'hF, rd);

        xact(1, 1, 32'd0, 4'hF, rd);
        xact(3, 1, 32'd0, 4'hF, rd);
        xact(2, 1, 32'hFFFF_FFFF, 4'hF, rd);
        idle(2);
        xact(3, 0, 0, 4'hF, rd);
        chk("carry_hi", rd, 32'd1);

        xact(0, 1, 32'd0, 4'hF, rd);
        xact(3, 1, 32'd0, 4'hF, rd);
        xact(2, 1, 32'd0, 4'hF, rd);
        xact(5, 1, 32'd0, 4'hF, rd);
        xact(4, 1, 32'h10, 4'hF, rd);
        xact(0, 1, 32'd1, 4'hF, rd);
        idle(30);
        chk("irq_high", timer_irq, 1'b1);
        xact(4, 1, 32'h100, 4'hF, rd);
        idle(2);
        chk("irq_dropped", timer_irq, 1'b0);

        xact(0, 1, 32'd0, 4'hF, rd);
        xact(2, 1, 32'd0, 4'hF, rd);
        xact(2, 1, 32'hAABB_CCDD, 4'b0010, rd);
        xact(2, 0, 0, 4'hF, rd);
        chk("masked_time_lo", rd, 32'h0000_CC00);
        xact(2, 1, 32'h1234_5678, 4'b0000, rd);
        xact(2, 0, 0, 4'hF, rd);

        xact(4, 1, 32'd0, 4'hF, rd);
        xact(0, 1, 32'd1, 4'hF, rd);
        idle(3);
        bus.request = 1'b1;
        bus.we_re   = 1'b0;
        bus.address = AW'(4);
        tick();
        chk("wait_no_valid", bus.valid, 1'b0);
        irq_on = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_valid", bus.valid, 1'b0);
            chk("abort_irq", timer_irq, 1'b0);
        end
        bus.request = 1'b0;
        rst = 1'b1;
        model_reset();
        irq_on = 1'b1;
        idle(2);
        xact(4, 0, 0, 4'hF, rd);
        chk("cmp_after_abort", rd, 32'hFFFF_FFFF);
        xact(0, 0, 0, 4'hF, rd);
        chk("ctrl_after_abort", rd, 32'd0);
        xact(2, 0, 0, 4'hF, rd);
        chk("time_after_abort", rd, 32'd0);

        for (int i = 0; i < 250; i++) begin
            a = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 1) d = $urandom_range(0, 3);
            if (a == 3 || a == 5) d = $urandom_range(0, 1);
            xact(a, w, d, 4'($urandom_range(0, 15)), rd);
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
